// File: rtl/top_level_pkg.sv
// Shared definitions for the decrypt/depad engine: tap table, FSM states
// and the single-step LFSR function used by both the search and decrypt paths.
package top_level_pkg;

    localparam int N_TAPS = 9;
    localparam int MSG_LEN = 64;
    localparam logic [7:0] MSG_BASE = 8'd64;
    localparam logic [6:0] SPACE7 = 7'h20;
    localparam logic [7:0] SPACE8 = 8'h20;

    // Candidate feedback tap patterns, searched in index order.
    localparam logic [6:0] TAPS [N_TAPS] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEARCH,
        S_SCAN,
        S_WRITE,
        S_DONE
    } state_t;

    // One LFSR step: shift left, new LSB is the parity of the tapped bits.
    function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] taps);
        return {s[5:0], ^(s & taps)};
    endfunction

endpackage

// File: rtl/dat_mem.sv
// 256-byte single-port data memory: combinational read, write on rising edge.
// Contents are deliberately not reset.
module dat_mem (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    logic [7:0] Core [256];

    assign rdata = Core[addr];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            Core[addr] <= wdata;
        end
    end

endmodule

// File: rtl/top_level.sv
// Decrypt/depad engine. Reads the encrypted message from mem[64..127],
// recovers seed and taps from the known leading spaces, decrypts, flags
// parity errors, strips leading spaces and writes the result to mem[0..63].
// Memory handshake: one access per cycle; reads are combinational on addr,
// writes commit on the rising edge when we is high.
module top_level
    import top_level_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic Start,
    output logic Ack
);

    state_t      state;
    state_t      state_nx;

    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        we;

    logic [6:0]  idx;        // load / scan position
    logic [6:0]  src;        // source index during write (may exceed 63)
    logic [5:0]  n;          // destination index during write
    logic [3:0]  k;          // tap pattern under test
    logic        wr_phase;   // 0: read source byte, 1: write result byte
    logic [6:0]  s0;
    logic [6:0]  t [1:9];    // expected keystream s[1..9]
    logic [6:0]  s;          // running keystream
    logic [6:0]  taps_sel;
    logic [7:0]  byte_hold;

    logic [6:0]  sv;
    logic        match;
    logic        scan_hit;

    dat_mem DM1 (
        .clk   (Clk),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    // Does TAPS[k] stepped from s0 reproduce the cached keystream t[1..9]?
    always_comb begin
        sv    = s0;
        match = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            sv = lfsr_step(sv, TAPS[k]);
            if (sv != t[j]) begin
                match = 1'b0;
            end
        end
    end

    // A byte ends the leading-space run if it has bad parity or is not a space.
    assign scan_hit = (^rdata) | ((rdata[6:0] ^ s) != SPACE7);

    // FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and memory port control.
    always_comb begin
        state_nx = state;
        addr     = '0;
        we       = 1'b0;
        wdata    = '0;
        Ack      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!Start) state_nx = S_LOAD;
            end
            S_LOAD: begin
                addr = MSG_BASE + {1'b0, idx};
                if (idx == 7'd9) state_nx = S_SEARCH;
            end
            S_SEARCH: begin
                if (match || k == 4'd8) state_nx = S_SCAN;
            end
            S_SCAN: begin
                addr = MSG_BASE + {1'b0, idx};
                if (scan_hit || idx == 7'd63) state_nx = S_WRITE;
            end
            S_WRITE: begin
                if (!wr_phase) begin
                    addr = MSG_BASE + {1'b0, src};
                end else begin
                    addr  = {2'b00, n};
                    we    = 1'b1;
                    wdata = byte_hold;
                    if (n == 6'd63) state_nx = S_DONE;
                end
            end
            S_DONE: begin
                Ack = 1'b1;
                if (Start) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath: counters, seed/target cache, keystream and output byte.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            idx       <= '0;
            src       <= '0;
            n         <= '0;
            k         <= '0;
            wr_phase  <= 1'b0;
            s0        <= '0;
            s         <= '0;
            taps_sel  <= '0;
            byte_hold <= '0;
            for (int j = 1; j <= 9; j++) t[j] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    idx      <= '0;
                    k        <= '0;
                    n        <= '0;
                    wr_phase <= 1'b0;
                end
                S_LOAD: begin
                    if (idx == 7'd0) s0 <= rdata[6:0] ^ SPACE7;
                    else             t[idx[3:0]] <= rdata[6:0] ^ SPACE7;
                    idx <= idx + 7'd1;
                end
                S_SEARCH: begin
                    // Values latched on the exit cycle are the ones that stick;
                    // an exhausted search falls back to pattern 0.
                    taps_sel <= match ? TAPS[k] : TAPS[0];
                    s        <= s0;
                    idx      <= '0;
                    k        <= k + 4'd1;
                end
                S_SCAN: begin
                    if (scan_hit) begin
                        src <= idx;
                    end else begin
                        s   <= lfsr_step(s, taps_sel);
                        idx <= idx + 7'd1;
                        if (idx == 7'd63) src <= 7'd64;
                    end
                end
                S_WRITE: begin
                    if (!wr_phase) begin
                        byte_hold <= src[6] ? SPACE8 : {^rdata, rdata[6:0] ^ s};
                        wr_phase  <= 1'b1;
                    end else begin
                        wr_phase <= 1'b0;
                        n        <= n + 6'd1;
                        src      <= src + 7'd1;
                        s        <= lfsr_step(s, taps_sel);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_top_level.sv
// Bench for the decrypt/depad engine.
module tb_top_level;

    logic Clk = 1'b0;
    logic Reset;
    logic Start;
    logic Ack;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] cbuf [64];
    logic [7:0] exp_q [$];

    localparam logic [6:0] TAP_TAB [9] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };
    localparam string MSG = "We just lost the summer to 141L";

    top_level dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .Ack   (Ack)
    );

    always #5 Clk = ~Clk;

    function automatic logic [6:0] next_key(input logic [6:0] s, input logic [6:0] taps);
        int ones;
        ones = $countones(s & taps);
        return {s[5:0], 1'b0} | ((ones % 2 == 1) ? 7'd1 : 7'd0);
    endfunction

    // Encrypt: pre spaces, message, then space padding to 64 bytes.
    task automatic build(input logic [6:0] taps, input logic [6:0] seed, input int pre, input string msg);
        logic [6:0] s;
        logic [6:0] x;
        logic [7:0] p;
        s = seed;
        for (int i = 0; i < 64; i++) begin
            if (i < pre || i - pre >= msg.len()) p = 8'h20;
            else p = msg[i - pre];
            x = p[6:0] ^ s;
            cbuf[i] = {^x, x};
            s = next_key(s, taps);
        end
    endtask

    task automatic load_mem();
        for (int i = 0; i < 64; i++) begin
            dut.DM1.Core[64 + i] = cbuf[i];
            dut.DM1.Core[i] = 8'h5A;
        end
    endtask

    // Reference: recover seed/taps from the known pad, decrypt, strip, shift.
    task automatic model();
        logic [6:0] ks [64];
        logic [6:0] s;
        logic [6:0] sel;
        bit found;
        bit ok;
        int f;
        int src;
        sel = TAP_TAB[0];
        found = 0;
        for (int kk = 0; kk < 9; kk++) begin
            if (!found) begin
                ok = 1;
                s = cbuf[0][6:0] ^ 7'h20;
                for (int j = 1; j <= 9; j++) begin
                    s = next_key(s, TAP_TAB[kk]);
                    if (s != (cbuf[j][6:0] ^ 7'h20)) ok = 0;
                end
                if (ok) begin
                    sel = TAP_TAB[kk];
                    found = 1;
                end
            end
        end
        ks[0] = cbuf[0][6:0] ^ 7'h20;
        for (int i = 1; i < 64; i++) ks[i] = next_key(ks[i-1], sel);
        f = 64;
        for (int i = 0; i < 64; i++)
            if (f == 64 && ((^cbuf[i]) || ((cbuf[i][6:0] ^ ks[i]) != 7'h20))) f = i;
        exp_q.delete();
        for (int nn = 0; nn < 64; nn++) begin
            src = f + nn;
            if (src < 64) exp_q.push_back({^cbuf[src], cbuf[src][6:0] ^ ks[src]});
            else exp_q.push_back(8'h20);
        end
    endtask

    task automatic run_engine(output bit done);
        done = 0;
        @(negedge Clk);
        Start = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(posedge Clk);
            #1;
            if (Ack === 1'b1) done = 1;
        end
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    function automatic string random_msg(input int maxlen);
        string m;
        int len;
        byte ch;
        m = "";
        len = $urandom_range(0, maxlen);
        for (int i = 0; i < len; i++) begin
            ch = ($urandom_range(0, 5) == 0) ? 8'h20 : 8'($urandom_range(33, 126));
            m = {m, string'(ch)};
        end
        return m;
    endfunction

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b1;
        dut.DM1.Core[64] = 8'hC3;
        dut.DM1.Core[0] = 8'h5A;
        repeat (3) @(posedge Clk);
        #1;
        n_vec++;
        if (Ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", Ack); end
        @(negedge Clk);
        Reset = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        n_vec++;
        if (Ack !== 1'b0) begin n_err++; $display("FAIL idle_ack: got %b want 0", Ack); end
        n_vec++;
        if (dut.DM1.Core[64] !== 8'hC3) begin n_err++; $display("FAIL mem_kept: got %h want c3", dut.DM1.Core[64]); end
        n_vec++;
        if (dut.DM1.Core[0] !== 8'h5A) begin n_err++; $display("FAIL idle_nowrite: got %h want 5a", dut.DM1.Core[0]); end
    endtask

    task automatic test_basic();
        bit done;
        build(7'h6A, 7'h35, 12, MSG);
        load_mem();
        run_engine(done);
        n_vec++;
        if (!done) begin n_err++; $display("FAIL basic_ack: got 0 want 1"); end
        n_vec++;
        if (Ack !== 1'b0) begin n_err++; $display("FAIL basic_ack_drop: got %b want 0", Ack); end
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(i < MSG.len() ? 8'(MSG[i]) : 8'h20);
        for (int i = 0; i < 64; i++) begin
            logic [7:0] e;
            logic [7:0] a;
            e = exp_q.pop_front();
            a = dut.DM1.Core[i];
            n_vec++;
            if (a !== e) begin n_err++; $display("FAIL basic byte %0d: got %h want %h", i, a, e); end
        end
    endtask

    task automatic test_flips();
        bit done;
        logic [7:0] ref_b [64];
        build(7'h6A, 7'h35, 12, MSG);
        cbuf[30] = cbuf[30] ^ 8'h08;
        cbuf[40] = cbuf[40] ^ 8'h80;
        load_mem();
        for (int i = 0; i < 64; i++) ref_b[i] = i < MSG.len() ? 8'(MSG[i]) : 8'h20;
        ref_b[18] = 8'h80 | (ref_b[18] ^ 8'h08);
        ref_b[28] = 8'h80 | ref_b[28];
        run_engine(done);
        n_vec++;
        if (!done) begin n_err++; $display("FAIL flips_ack: got 0 want 1"); end
        for (int i = 0; i < 64; i++) begin
            n_vec++;
            if (dut.DM1.Core[i] !== ref_b[i]) begin
                n_err++; $display("FAIL flips byte %0d: got %h want %h", i, dut.DM1.Core[i], ref_b[i]);
            end
        end
    endtask

    task automatic test_all_taps();
        bit done;
        for (int kk = 0; kk < 9; kk++) begin
            build(TAP_TAB[kk], 7'h01, 10, random_msg(54));
            load_mem();
            model();
            run_engine(done);
            n_vec++;
            if (!done) begin n_err++; $display("FAIL taps%0d_ack: got 0 want 1", kk); end
            for (int i = 0; i < 64; i++) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                n_vec++;
                if (dut.DM1.Core[i] !== e) begin
                    n_err++; $display("FAIL taps%0d byte %0d: got %h want %h", kk, i, dut.DM1.Core[i], e);
                end
            end
        end
    endtask

    task automatic test_inner_spaces();
        bit done;
        string want;
        want = "Ajok";
        build(TAP_TAB[3], 7'h4D, 15, "   Ajok");
        load_mem();
        run_engine(done);
        n_vec++;
        if (!done) begin n_err++; $display("FAIL inner_ack: got 0 want 1"); end
        for (int i = 0; i < 64; i++) begin
            logic [7:0] e;
            e = i < 4 ? 8'(want[i]) : 8'h20;
            n_vec++;
            if (dut.DM1.Core[i] !== e) begin
                n_err++; $display("FAIL inner byte %0d: got %h want %h", i, dut.DM1.Core[i], e);
            end
        end
    endtask

    task automatic test_corrupt_first();
        bit done;
        string m;
        logic [7:0] e;
        m = "";
        for (int i = 0; i < 15; i++) m = {m, " "};
        m = {m, "xyz"};
        build(TAP_TAB[7], 7'h22, 10, m);
        cbuf[24] = cbuf[24] ^ 8'h01;
        load_mem();
        run_engine(done);
        n_vec++;
        if (!done) begin n_err++; $display("FAIL corrupt_ack: got 0 want 1"); end
        for (int i = 0; i < 64; i++) begin
            case (i)
                0: e = 8'hA1;
                1: e = 8'h78;
                2: e = 8'h79;
                3: e = 8'h7A;
                default: e = 8'h20;
            endcase
            n_vec++;
            if (dut.DM1.Core[i] !== e) begin
                n_err++; $display("FAIL corrupt byte %0d: got %h want %h", i, dut.DM1.Core[i], e);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        bit done;
        build(7'h6A, 7'h35, 12, MSG);
        load_mem();
        @(negedge Clk);
        Start = 1'b0;
        repeat (80) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        n_vec++;
        if (Ack !== 1'b0) begin n_err++; $display("FAIL midrst_ack: got %b want 0", Ack); end
        repeat (2) @(posedge Clk);
        #1;
        n_vec++;
        if (Ack !== 1'b0) begin n_err++; $display("FAIL midrst_hold_ack: got %b want 0", Ack); end
        @(negedge Clk);
        Reset = 1'b0;
        run_engine(done);
        n_vec++;
        if (!done) begin n_err++; $display("FAIL midrst_rerun_ack: got 0 want 1"); end
        for (int i = 0; i < 64; i++) begin
            logic [7:0] e;
            e = i < MSG.len() ? 8'(MSG[i]) : 8'h20;
            n_vec++;
            if (dut.DM1.Core[i] !== e) begin
                n_err++; $display("FAIL midrst byte %0d: got %h want %h", i, dut.DM1.Core[i], e);
            end
        end
    endtask

    task automatic test_random();
        bit done;
        int pre;
        for (int it = 0; it < 20; it++) begin
            pre = $urandom_range(10, 15);
            build(TAP_TAB[$urandom_range(0, 8)], 7'($urandom_range(1, 127)), pre, random_msg(64 - pre));
            for (int i = 24; i < 64; i++)
                if ($urandom_range(0, 7) == 0) cbuf[i] = cbuf[i] ^ (8'h01 << $urandom_range(0, 7));
            load_mem();
            model();
            run_engine(done);
            n_vec++;
            if (!done) begin n_err++; $display("FAIL rand%0d_ack: got 0 want 1", it); end
            for (int i = 0; i < 64; i++) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                n_vec++;
                if (dut.DM1.Core[i] !== e) begin
                    n_err++; $display("FAIL rand%0d byte %0d: got %h want %h", it, i, dut.DM1.Core[i], e);
                end
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b1;
        test_reset();
        test_basic();
        test_flips();
        test_all_taps();
        test_inner_spaces();
        test_corrupt_first();
        test_reset_mid_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
